sqncgen: RTL and testbench

Serial pattern transmitter that drives the one-bit `in` line of the team's sequence detectors. It accepts a parallel pattern word through a valid/ready handshake and shifts it out MSB-first, one bit per clock. It can repeat the pattern a programmed number of times with a fixed idle gap between repetitions. Its main users are the detector testbenches and the on-chip self-test path, where it sits directly upstream of the detector.

---
 rtl/sqnc_pkg.sv | 19 +
 rtl/sqnc_shreg.sv | 28 ++
 rtl/sqncgen.sv | 158 +++++++++++++++
 tb/tb_sqncgen.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/sqnc_pkg.sv
// Shared types and helpers for the serial pattern generator.
// The one-hot state encoding lets decode logic test a single bit.
package sqnc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_SHIFT = 3'b010,
    ST_GAP   = 3'b100
  } state_t;

  // Target sequence of the companion detector.
  localparam logic [4:0] DEFAULT_PATTERN = 5'b10111;

  // Out-of-range or zero lengths fall back to the full pattern width.
  function automatic int unsigned clamp_len(input int unsigned l, input int unsigned w);
    return ((l == 0) || (l > w)) ? w : l;
  endfunction

endpackage

// File: rtl/sqnc_shreg.sv
// Loadable left-shift register; ser_out is the MSB.
// Load has priority over shift; one cycle from load/shift to ser_out.
module sqnc_shreg #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] d,
  output logic             ser_out
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift_en) begin
      q <= q << 1;
    end
  end

  assign ser_out = q[WIDTH-1];

endmodule

// File: rtl/sqncgen.sv
// Serial pattern transmitter: accepts a word via valid/ready, shifts it out MSB-first with
// optional repeats; first bit one cycle after accept; start_ready only in IDLE.
module sqncgen
  import sqnc_pkg::*;
#(
  parameter int unsigned WIDTH    = 5,
  parameter int unsigned GAP      = 2,
  parameter logic        IDLE_BIT = 1'b0,
  parameter int unsigned RPT_W    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_valid,
  output logic                       start_ready,
  input  logic [WIDTH-1:0]           pattern,
  input  logic [$clog2(WIDTH+1)-1:0] len,
  input  logic [RPT_W-1:0]           rpt,
  input  logic                       abort,
  output logic                       out,
  output logic                       out_valid,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned LW = $clog2(WIDTH + 1);
  localparam int unsigned GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  state_t           state;
  logic [WIDTH-1:0] pat_q;
  logic [LW-1:0]    len_q;
  logic [LW-1:0]    bit_cnt;
  logic [RPT_W-1:0] rpt_cnt;
  logic [GW-1:0]    gap_cnt;

  logic [LW-1:0]    len_c;
  logic [WIDTH-1:0] aligned_in;
  logic             sr_load;
  logic             sr_shift;
  logic [WIDTH-1:0] sr_d;
  logic             sr_msb;

  assign len_c       = LW'(clamp_len(32'(len), WIDTH));
  // Left-justify the used bits so the first bit to send sits at the MSB.
  assign aligned_in  = pattern << (WIDTH - 32'(len_c));
  assign start_ready = (state == ST_IDLE);
  assign busy        = (state != ST_IDLE);

  // The shift register holds the bits that follow the one currently on out.
  always_comb begin
    sr_load  = 1'b0;
    sr_shift = 1'b0;
    sr_d     = pat_q << 1;
    if (state == ST_IDLE) begin
      sr_load = start_valid;
      sr_d    = aligned_in << 1;
    end else if (!abort) begin
      if (state == ST_SHIFT) begin
        if (bit_cnt != '0) begin
          sr_shift = 1'b1;
        end else if ((rpt_cnt != '0) && (GAP == 0)) begin
          sr_load = 1'b1;
        end
      end else if ((state == ST_GAP) && (gap_cnt == '0)) begin
        sr_load = 1'b1;
      end
    end
  end

  sqnc_shreg #(
    .WIDTH(WIDTH)
  ) u_shreg (
    .clk     (clk),
    .rst     (rst),
    .load    (sr_load),
    .shift_en(sr_shift),
    .d       (sr_d),
    .ser_out (sr_msb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      bit_cnt   <= '0;
      rpt_cnt   <= '0;
      gap_cnt   <= '0;
      out       <= IDLE_BIT;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_valid) begin
            state     <= ST_SHIFT;
            pat_q     <= aligned_in;
            len_q     <= len_c;
            bit_cnt   <= len_c - LW'(1);
            rpt_cnt   <= rpt;
            out       <= aligned_in[WIDTH-1];
            out_valid <= 1'b1;
            done      <= (len_c == LW'(1)) && (rpt == '0);
          end
        end
        ST_SHIFT: begin
          if (abort) begin
            state     <= ST_IDLE;
            out       <= IDLE_BIT;
            out_valid <= 1'b0;
          end else if (bit_cnt != '0) begin
            out     <= sr_msb;
            bit_cnt <= bit_cnt - LW'(1);
            // done marks the cycle the final bit is on out, so it is set as that bit loads.
            done    <= (bit_cnt == LW'(1)) && (rpt_cnt == '0);
          end else if (rpt_cnt != '0) begin
            rpt_cnt <= rpt_cnt - RPT_W'(1);
            bit_cnt <= len_q - LW'(1);
            if (GAP == 0) begin
              out       <= pat_q[WIDTH-1];
              out_valid <= 1'b1;
              done      <= (len_q == LW'(1)) && (rpt_cnt == RPT_W'(1));
            end else begin
              state     <= ST_GAP;
              gap_cnt   <= GW'(GAP - 1);
              out       <= IDLE_BIT;
              out_valid <= 1'b0;
            end
          end else begin
            state     <= ST_IDLE;
            out       <= IDLE_BIT;
            out_valid <= 1'b0;
          end
        end
        ST_GAP: begin
          if (abort) begin
            state     <= ST_IDLE;
            out       <= IDLE_BIT;
            out_valid <= 1'b0;
          end else if (gap_cnt == '0) begin
            state     <= ST_SHIFT;
            out       <= pat_q[WIDTH-1];
            out_valid <= 1'b1;
            done      <= (len_q == LW'(1)) && (rpt_cnt == '0);
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        default: begin
          state     <= ST_IDLE;
          out       <= IDLE_BIT;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sqncgen.sv
// Self-checking bench for sqncgen: per-cycle expectations come from a queue-based model
// that expands each request into its bit/gap stream.
module tb_sqncgen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_valid;
  logic       start_ready;
  logic [4:0] pattern;
  logic [2:0] len;
  logic [7:0] rpt;
  logic       abort;
  logic       out;
  logic       out_valid;
  logic       busy;
  logic       done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sqncgen dut (
    .clk        (clk),
    .rst        (rst),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .pattern    (pattern),
    .len        (len),
    .rpt        (rpt),
    .abort      (abort),
    .out        (out),
    .out_valid  (out_valid),
    .busy       (busy),
    .done       (done)
  );

  // Observed vector layout: {start_ready, busy, out, out_valid, done}
  function automatic logic [4:0] obs();
    return {start_ready, busy, out, out_valid, done};
  endfunction

  task automatic chk(input string tag, input logic [4:0] o, input logic [4:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: {rdy,busy,out,vld,done} got %b want %b", tag, o, e);
    end
  endtask

  // Called at a negedge while idle; returns at the negedge of the first idle cycle after.
  task automatic xfer(input logic [4:0] p, input logic [2:0] l, input logic [7:0] r,
                      input int abort_at, input bit abort_on_accept, input string tag);
    logic [2:0] exq[$];
    int L;
    L = ((l == 0) || (l > 5)) ? 5 : int'(l);
    for (int rep = 0; rep <= int'(r); rep++) begin
      for (int k = 0; k < L; k++)
        exq.push_back({p[L-1-k], 1'b1, (rep == int'(r)) && (k == L - 1)});
      if (rep < int'(r)) repeat (2) exq.push_back(3'b000);
    end
    chk({tag, " ready"}, obs(), 5'b10000);
    start_valid = 1'b1;
    pattern     = p;
    len         = l;
    rpt         = r;
    abort       = abort_on_accept;
    @(negedge clk);
    start_valid = 1'b0;
    abort       = 1'b0;
    pattern     = 5'($urandom);
    len         = 3'($urandom);
    rpt         = 8'($urandom);
    for (int i = 0; i < exq.size(); i++) begin
      chk($sformatf("%s c%0d", tag, i), obs(), {2'b01, exq[i]});
      if (i == abort_at) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        break;
      end
      @(negedge clk);
    end
    chk({tag, " end"}, obs(), 5'b10000);
  endtask

  initial begin
    rst         = 1'b1;
    start_valid = 1'b0;
    pattern     = '0;
    len         = '0;
    rpt         = '0;
    abort       = 1'b0;
    #1;
    chk("reset", obs(), 5'b10000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("after reset", obs(), 5'b10000);
    @(negedge clk);

    xfer(5'b10111, 3'd5, 8'd0, -1, 1'b0, "p10111");
    xfer(5'b10111, 3'd5, 8'd2, -1, 1'b0, "rpt2");
    xfer(5'b00110, 3'd3, 8'd0, -1, 1'b0, "len3");
    xfer(5'b00110, 3'd0, 8'd0, -1, 1'b0, "len0");
    xfer(5'b01011, 3'd7, 8'd1, -1, 1'b0, "len7");
    xfer(5'b11001, 3'd1, 8'd3, -1, 1'b0, "len1");
    xfer(5'b00001, 3'd1, 8'd255, -1, 1'b0, "rptmax");
    xfer(5'b10111, 3'd5, 8'd1, 2, 1'b0, "abort_shift");
    xfer(5'b10111, 3'd5, 8'd1, 6, 1'b0, "abort_gap");
    xfer(5'b01101, 3'd4, 8'd0, -1, 1'b1, "abort_idle");

    // Async reset landing in the first gap cycle of a three-burst transfer.
    start_valid = 1'b1;
    pattern     = 5'b10111;
    len         = 3'd5;
    rpt         = 8'd2;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst gap", obs(), 5'b01000);
    rst = 1'b1;
    #1;
    chk("rst async", obs(), 5'b10000);
    @(negedge clk);
    chk("rst held", obs(), 5'b10000);
    rst = 1'b0;
    @(negedge clk);
    xfer(5'b01101, 3'd4, 8'd1, -1, 1'b0, "post_rst");

    // Back-to-back requests: two bits each, then exactly one idle cycle.
    pattern     = 5'b00010;
    len         = 3'd2;
    rpt         = 8'd0;
    start_valid = 1'b1;
    @(negedge clk);
    for (int j = 1; j <= 9; j++) begin
      case (j % 3)
        1:       chk($sformatf("b2b c%0d", j), obs(), 5'b01110);
        2:       chk($sformatf("b2b c%0d", j), obs(), 5'b01011);
        default: chk($sformatf("b2b c%0d", j), obs(), 5'b10000);
      endcase
      if (j < 9) @(negedge clk);
    end
    start_valid = 1'b0;
    @(negedge clk);

    for (int n = 0; n < 25; n++) begin
      int ab;
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : -1;
      xfer(5'($urandom), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 3)), ab,
           1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
